// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one fifo_sync write port.
// A grant is held until a last beat or MaxBeats accepted beats.
module fifo_wr_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 4,
  parameter int MaxBeats  = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  input  logic [NumReq-1:0]             req_last_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic                          m_valid_o,
  output logic [DataWidth-1:0]          m_data_o,
  input  logic                          m_ready_i,
  output logic [NumReq-1:0]             grant_o,
  output logic                          busy_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBeats + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     gidx_q, gidx_d;
  logic [NumReq-1:0]   grant_q, grant_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_vld;
  logic                g_last;
  logic                beat;

  // Downward scan so the lowest offset from the pointer wins.
  always_comb begin : pick
    int              j;
    logic [IdxW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    cand     = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      j    = (int'(ptr_q) + i) % NumReq;
      cand = IdxW'(j);
      if (req_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin : datapath
    m_valid_o   = 1'b0;
    m_data_o    = '0;
    req_ready_o = '0;
    g_last      = 1'b0;
    if (state_q == LOCKED) begin
      for (int k = 0; k < NumReq; k++) begin
        if (grant_q[k]) begin
          m_valid_o      = req_valid_i[k];
          m_data_o       = req_data_i[k*DataWidth +: DataWidth];
          req_ready_o[k] = m_ready_i;
          g_last         = req_last_i[k];
        end
      end
    end
  end

  assign beat = m_valid_o & m_ready_i;

  always_comb begin : fsm
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LOCKED;
          gidx_d  = pick_idx;
          grant_d = NumReq'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (g_last || cnt_q == CntW'(MaxBeats - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (gidx_q == IdxW'(NumReq - 1)) ?
                      '0 : gidx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == LOCKED);

endmodule
